// File: rtl/noise_burst_ctrl.sv
// Attack/hold/release envelope sequencer for the LFSR noise source, with valid/ready sample output.
// Define OVERRUN_CNT_EN to add overrun_cnt_o, a saturating count of dropped samples.
module noise_burst_ctrl #(
    parameter int WIDTH  = 24,
    parameter int DIV_W  = 16,
    parameter int HOLD_W = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    trig_i,
    input  logic [DIV_W-1:0]        div_i,
    input  logic [7:0]              atk_step_i,
    input  logic [HOLD_W-1:0]       hold_i,
    input  logic [7:0]              rel_step_i,
    input  logic signed [WIDTH-1:0] noise_i,
    output logic                    noise_adv_o,
    output logic signed [WIDTH-1:0] sample_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic                    busy_o,
    output logic                    overrun_o
`ifdef OVERRUN_CNT_EN
    ,
    output logic [15:0]             overrun_cnt_o
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        ATTACK,
        HOLD,
        RELEASE
    } state_e;

    state_e              state_q, state_d;
    logic [8:0]          gain_q, gain_d;
    logic [DIV_W-1:0]    div_cnt_q;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [DIV_W-1:0]    div_q;
    logic [7:0]          atk_q;
    logic [HOLD_W-1:0]   hold_q;
    logic [7:0]          rel_q;

    logic                tick;
    logic                drop;
    logic [9:0]          atk_sum;

    logic signed [WIDTH+9:0] noise_ext;
    logic signed [WIDTH+9:0] gain_ext;
    logic signed [WIDTH+9:0] product;
    logic [WIDTH-1:0]        sample_next;
    logic                    unused_product_bits;

    assign tick        = (state_q != IDLE) && (div_cnt_q == div_q);
    assign noise_adv_o = tick;
    assign drop        = tick && valid_o && !ready_i;

    // Gain is zero-extended so 256 stays positive; bits [WIDTH+7:8] are product >>> 8 truncated.
    assign noise_ext   = (WIDTH+10)'(noise_i);
    assign gain_ext    = (WIDTH+10)'({1'b0, gain_q});
    assign product     = noise_ext * gain_ext;
    assign sample_next = product[WIDTH+7:8];
    assign unused_product_bits = ^{product[WIDTH+9:WIDTH+8], product[7:0]};

    assign atk_sum = {1'b0, gain_q} + {2'b00, atk_q};

    always_comb begin
        state_d    = state_q;
        gain_d     = gain_q;
        hold_cnt_d = hold_cnt_q;
        if (trig_i) begin
            // A trigger overrides any envelope update due on the same tick; gain is kept.
            state_d    = ATTACK;
            hold_cnt_d = '0;
        end else if (tick) begin
            unique case (state_q)
                ATTACK: begin
                    if (atk_sum >= 10'd256) begin
                        gain_d     = 9'd256;
                        state_d    = HOLD;
                        hold_cnt_d = '0;
                    end else begin
                        gain_d = atk_sum[8:0];
                    end
                end
                HOLD: begin
                    if (hold_cnt_q == hold_q) begin
                        state_d = RELEASE;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end
                RELEASE: begin
                    if ({1'b0, rel_q} >= gain_q) begin
                        gain_d  = '0;
                        state_d = IDLE;
                    end else begin
                        gain_d = gain_q - {1'b0, rel_q};
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            gain_q     <= '0;
            hold_cnt_q <= '0;
            busy_o     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gain_q     <= gain_d;
            hold_cnt_q <= hold_cnt_d;
            busy_o     <= (state_d != IDLE);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q  <= '0;
            atk_q  <= '0;
            hold_q <= '0;
            rel_q  <= '0;
        end else if (trig_i) begin
            div_q  <= div_i;
            atk_q  <= (atk_step_i == 8'd0) ? 8'd1 : atk_step_i;
            hold_q <= hold_i;
            rel_q  <= (rel_step_i == 8'd0) ? 8'd1 : rel_step_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_cnt_q <= '0;
        end else if (trig_i && state_q == IDLE) begin
            div_cnt_q <= '0;
        end else if (state_q != IDLE) begin
            div_cnt_q <= tick ? '0 : div_cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sample_o  <= '0;
            valid_o   <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            if (tick && !drop) begin
                sample_o <= sample_next;
                valid_o  <= 1'b1;
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
            if (drop) begin
                overrun_o <= 1'b1;
            end else if (trig_i) begin
                overrun_o <= 1'b0;
            end
        end
    end

`ifdef OVERRUN_CNT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overrun_cnt_o <= '0;
        end else if (trig_i && state_q == IDLE) begin
            overrun_cnt_o <= '0;
        end else if (drop && overrun_cnt_o != 16'hFFFF) begin
            overrun_cnt_o <= overrun_cnt_o + 16'd1;
        end
    end
`endif

endmodule
